wr0_pixel_packer: RTL and testbench
===================================

// Module: wr0_pixel_packer
// PURPOSE
//  Write-side counterpart of the channel-0 read path: packs a 16-bit pixel stream into 64-bit words,
//  buffers them in an internal single-clock word FIFO and issues fixed-length burst writes to the DDR
//  frame buffer. Sits between the video input and the DDR write port, in the DDR controller clock domain.
// PARAMETERS
//  BURST_LEN    16      beats (64-bit words) per burst; power of 2, 2..64
//  FIFO_AW      9       word FIFO address width; depth 2**FIFO_AW words; 2**FIFO_AW >= 2*BURST_LEN
//  ADDR_W       28      DDR word-address width
//  FRAME_BASE   0       word address of pixel 0 of the frame
//  FRAME_WORDS  230400  words per frame (1280x720/4); multiple of BURST_LEN
// PORTS
//  clk          in   1        single clock, all logic on rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  pix_vs       in   1        frame sync; rising edge = new frame
//  pix_de       in   1        pixel valid
//  pix_data     in   16       pixel
//  wr_req       out  1        burst request
//  wr_addr      out  ADDR_W   burst start word address, stable while wr_req=1
//  wr_ack       in   1        request accepted (1 cycle)
//  wdata        out  64       burst data
//  wdata_valid  out  1        data beat valid
//  wdata_ready  in   1        controller accepts beat
//  wdata_last   out  1        final beat of burst
//  word_level   out  FIFO_AW+1 words in FIFO
//  overflow     out  1        sticky: a packed word was dropped
//  drop_cnt     out  16       dropped-word counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; pack phase 0; next address FRAME_BASE; FIFO empty.
//  Packing: pixel k of each group of 4 -> bits [16k+15:16k] (first pixel in [15:0]). Phase 2-bit counter
//   advances on pix_de; on 4th pixel the word is pushed next cycle. Pixel->FIFO latency 1 cycle.
//  Push with FIFO full: word dropped, FIFO unchanged, overflow set (cleared only by reset).
//  word_level: registered count, +1 push, -1 pop, unchanged on simultaneous push+pop.
//  FSM IDLE -> REQ when word_level >= BURST_LEN and no restart pending; wr_addr loaded from next address.
//  REQ: wr_req=1 held until wr_ack; ack in same cycle wr_req rises is accepted -> DATA next cycle.
//  DATA: FIFO head on wdata, wdata_valid=1; pop on valid&ready; beat counter 0..BURST_LEN-1;
//   wdata_last=1 on beat BURST_LEN-1; after last accepted beat -> IDLE, next address += BURST_LEN,
//   wraps to FRAME_BASE when it reaches FRAME_BASE+FRAME_WORDS. FIFO is never popped empty in DATA
//   (entry guaranteed BURST_LEN words); valid never drops mid-burst.
//  Frame restart: pix_vs rising edge (1-cycle registered edge detect) sets restart_pend. In IDLE with
//   restart_pend: FIFO cleared, pack phase cleared (partial word discarded), next address=FRAME_BASE,
//   restart_pend cleared; one cycle. A burst in REQ/DATA always completes first. Pixels arriving while
//   restart_pend=1 are discarded.
//  Mid-operation reset: immediate return to reset state; wr_req/wdata_valid drop asynchronously.
// CONFIGURATION
//  WR0_PACK_DROP_CNT_EN defined: drop_cnt counts dropped words, saturates at 16'hFFFF, cleared by reset.
//  Not defined: counter not built, drop_cnt tied to 16'h0; overflow flag still present.
// TESTING
//  Reset, pixels 0x0001..0x0004 with pix_de -> word_level=1, head word 0x0004_0003_0002_0001.
//  64 pixels, wr_ack after 3 cycles, wdata_ready=1 -> wr_req addr 0, 16 beats, wdata_last on 16th, level 0.
//  Frame of FRAME_WORDS words, ready toggling 50% -> bursts at 0,16,..; after wrap next burst addr FRAME_BASE.
//  No wr_ack, push 2**FIFO_AW+3 words -> overflow=1, level 512, drop_cnt=3 (macro on) / 0 (off).
//  6 pixels, pix_vs pulse, then 64 pixels -> first burst addr FRAME_BASE, first word = pixels 0..3 of new frame.
//  pix_vs during DATA burst -> burst completes 16 beats, then restart applied; rst_n low mid-burst -> all outputs 0.

Source files
------------

// File: rtl/wr0_pixel_packer.sv
// Pixel packer for DDR write channel 0: 4x16-bit pixels -> 64-bit words -> word FIFO -> fixed bursts.
// Optional saturating dropped-word counter is built when WR0_PACK_DROP_CNT_EN is defined.
module wr0_pixel_packer #(
  parameter int BURST_LEN   = 16,
  parameter int FIFO_AW     = 9,
  parameter int ADDR_W      = 28,
  parameter int FRAME_BASE  = 0,
  parameter int FRAME_WORDS = 230400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_vs,
  input  logic              pix_de,
  input  logic [15:0]       pix_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ack,
  output logic [63:0]       wdata,
  output logic              wdata_valid,
  input  logic              wdata_ready,
  output logic              wdata_last,
  output logic [FIFO_AW:0]  word_level,
  output logic              overflow,
  output logic [15:0]       drop_cnt,
  output logic [1:0]        o_dbg_state
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BCW   = $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0] LP_BASE      = ADDR_W'(FRAME_BASE);
  localparam logic [ADDR_W-1:0] LP_END       = ADDR_W'(FRAME_BASE + FRAME_WORDS);
  localparam logic [ADDR_W-1:0] LP_STEP      = ADDR_W'(BURST_LEN);
  localparam logic [BCW-1:0]    LP_LAST_BEAT = BCW'(BURST_LEN - 1);
  localparam logic [FIFO_AW:0]  LP_FULL      = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]  LP_BURST_LVL = (FIFO_AW + 1)'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DATA = 2'd2} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_vs_d;
  logic                r_restart_pend;
  logic [1:0]          r_phase;
  logic [47:0]         r_pack;
  logic                r_push;
  logic [63:0]         r_push_word;
  logic [63:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_wr_ptr;
  logic [FIFO_AW-1:0]  r_rd_ptr;
  logic [FIFO_AW:0]    r_level;
  logic                r_overflow;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W-1:0]   r_next_addr;
  logic [BCW-1:0]      r_beat;

  logic w_vs_rise, w_restart, w_pop, w_full, w_push_ok, w_drop;
  logic w_last_beat, w_burst_done, w_pix_take;

  assign w_vs_rise    = pix_vs & ~r_vs_d;
  assign w_restart    = (r_state == S_IDLE) & r_restart_pend;
  assign w_pop        = (r_state == S_DATA) & wdata_ready;
  assign w_full       = (r_level == LP_FULL);
  assign w_push_ok    = r_push & ~w_full & ~w_restart;
  assign w_drop       = r_push & w_full & ~w_restart;
  assign w_last_beat  = (r_beat == LP_LAST_BEAT);
  assign w_burst_done = w_pop & w_last_beat;
  assign w_pix_take   = pix_de & ~r_restart_pend;

  // Write data handshake: a beat transfers on a cycle with wdata_valid & wdata_ready both high;
  // once the burst is granted, valid stays high until the last beat transfers.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!r_restart_pend && (r_level >= LP_BURST_LVL)) w_state_nxt = S_REQ;
      S_REQ:   if (wr_ack) w_state_nxt = S_DATA;
      S_DATA:  if (w_burst_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_addr   <= '0;
      r_next_addr <= LP_BASE;
      r_beat      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && (w_state_nxt == S_REQ)) r_wr_addr <= r_next_addr;
      if (w_restart) r_next_addr <= LP_BASE;
      else if (w_burst_done)
        r_next_addr <= ((r_next_addr + LP_STEP) == LP_END) ? LP_BASE : (r_next_addr + LP_STEP);
      if (w_burst_done) r_beat <= '0;
      else if (w_pop)   r_beat <= r_beat + BCW'(1);
    end
  end

  // Frame sync edge and pixel packing; a pending restart swallows incoming pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d         <= 1'b0;
      r_restart_pend <= 1'b0;
      r_phase        <= 2'd0;
      r_pack         <= '0;
      r_push         <= 1'b0;
      r_push_word    <= '0;
    end else begin
      r_vs_d <= pix_vs;
      if (w_vs_rise)      r_restart_pend <= 1'b1;
      else if (w_restart) r_restart_pend <= 1'b0;
      r_push <= 1'b0;
      if (w_restart) begin
        r_phase <= 2'd0;
      end else if (w_pix_take) begin
        r_phase <= r_phase + 2'd1;
        case (r_phase)
          2'd0: r_pack[15:0]  <= pix_data;
          2'd1: r_pack[31:16] <= pix_data;
          2'd2: r_pack[47:32] <= pix_data;
          default: begin
            r_push      <= 1'b1;
            r_push_word <= {pix_data, r_pack};
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= r_push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_restart) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
        if (w_pop)     r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
        case ({w_push_ok, w_pop})
          2'b10:   r_level <= r_level + (FIFO_AW + 1)'(1);
          2'b01:   r_level <= r_level - (FIFO_AW + 1)'(1);
          default: r_level <= r_level;
        endcase
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef WR0_PACK_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
  end
  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 16'h0;
`endif

  assign wr_req      = (r_state == S_REQ);
  assign wr_addr     = r_wr_addr;
  assign wdata_valid = (r_state == S_DATA);
  assign wdata_last  = (r_state == S_DATA) & w_last_beat;
  // Head word is shown whenever the FIFO holds data so an empty FIFO reads as zero.
  assign wdata       = (r_level != '0) ? r_mem[r_rd_ptr] : 64'h0;
  assign word_level  = r_level;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wr0_pixel_packer.sv
// Self-checking bench for wr0_pixel_packer: random pixel/handshake stimulus against a queue-based
// model of packed words, burst addresses, restarts and overflow.
module tb_wr0_pixel_packer;

  localparam int BL     = 16;
  localparam int AW     = 9;
  localparam int ADDR_W = 28;
  localparam int BASE   = 100;
  localparam int FWORDS = 64;
  localparam int DEPTH  = 1 << AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pix_vs = 1'b0;
  logic              pix_de = 1'b0;
  logic [15:0]       pix_data = '0;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ack = 1'b0;
  logic [63:0]       wdata;
  logic              wdata_valid;
  logic              wdata_ready = 1'b0;
  logic              wdata_last;
  logic [AW:0]       word_level;
  logic              overflow;
  logic [15:0]       drop_cnt;
  logic [1:0]        dbg_state;

  wr0_pixel_packer #(
    .BURST_LEN(BL), .FIFO_AW(AW), .ADDR_W(ADDR_W), .FRAME_BASE(BASE), .FRAME_WORDS(FWORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_vs(pix_vs), .pix_de(pix_de), .pix_data(pix_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack), .wdata(wdata),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata_last(wdata_last),
    .word_level(word_level), .overflow(overflow), .drop_cnt(drop_cnt), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  logic [15:0] m_pix[$];
  logic [ADDR_W-1:0] addr_log[$];
  logic [ADDR_W-1:0] m_next_addr = ADDR_W'(BASE);
  int m_committed = 0;
  int m_beat = 0;
  int beats_total = 0;
  int m_drop = 0;
  int ack_mode = 0;
  int ack_dly = 0;
  int ack_wait = 0;
  bit ready_rand = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_pix.delete();
    addr_log.delete();
    m_next_addr = ADDR_W'(BASE);
    m_committed = 0;
    m_beat = 0;
    beats_total = 0;
    m_drop = 0;
  endtask

  task automatic model_push_pixel(input logic [15:0] p);
    logic [63:0] w;
    m_pix.push_back(p);
    if (m_pix.size() == 4) begin
      w = {m_pix[3], m_pix[2], m_pix[1], m_pix[0]};
      m_pix.delete();
      if (exp_q.size() >= DEPTH) m_drop++;
      else exp_q.push_back(w);
    end
  endtask

  // A restart keeps only the words an already granted burst still has to deliver.
  task automatic model_restart();
    m_pix.delete();
    while (exp_q.size() > 0 && exp_q.size() > m_committed) void'(exp_q.pop_back());
    m_next_addr = ADDR_W'(BASE);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pix(input logic [15:0] p);
    pix_de = 1'b1;
    pix_data = p;
    model_push_pixel(p);
    @(posedge clk);
    #1;
    pix_de = 1'b0;
  endtask

  task automatic send_rand(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_pix(16'($urandom));
      if (gaps && ($urandom_range(0, 3) == 0)) idle(1);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    pix_vs = 1'b0;
    pix_de = 1'b0;
    ack_mode = 0;
    ready_rand = 1'b0;
    model_clear();
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic pulse_vs();
    pix_vs = 1'b1;
    model_restart();
    idle(2);
    pix_vs = 1'b0;
    idle(1);
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int n = 0;
    while (beats_total < target && n < budget) begin
      idle(1);
      n++;
    end
    chk(name, 64'(beats_total), 64'(target));
    idle(3);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!wdata_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", wdata_valid, 1'b1);
  endtask

  // ---------------- handshake responders ----------------
  always begin
    @(posedge clk);
    #1;
    wdata_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (ack_mode == 2) begin
      wr_ack = 1'b1;
    end else if (ack_mode == 1 && rst_n && wr_req && !wr_ack) begin
      if (ack_wait >= ack_dly) begin
        wr_ack = 1'b1;
        ack_wait = 0;
      end else begin
        ack_wait++;
      end
    end else begin
      wr_ack = 1'b0;
      ack_wait = 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_req && wr_ack) begin
        chk("wr_addr", 64'(wr_addr), 64'(m_next_addr));
        addr_log.push_back(wr_addr);
        m_next_addr = (int'(m_next_addr) + BL == BASE + FWORDS) ? ADDR_W'(BASE)
                                                                : m_next_addr + ADDR_W'(BL);
        m_committed += BL;
      end
      if (wdata_valid) begin
        chk("valid_in_granted_burst", 64'(m_committed > 0), 64'd1);
        if (exp_q.size() == 0) chk("wdata_underrun", 64'(exp_q.size()), 64'd1);
        else chk("wdata", wdata, exp_q[0]);
        chk("wdata_last", wdata_last, (m_beat == BL - 1));
        if (wdata_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_committed--;
          m_beat = (m_beat + 1) % BL;
          beats_total++;
        end
      end else begin
        chk("last_without_valid", wdata_last, 1'b0);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] exp_drop;
`ifdef WR0_PACK_DROP_CNT_EN
    exp_drop = 16'd3;
`else
    exp_drop = 16'd0;
`endif
    reset_dut();

    // Reset state
    chk("rst_wr_req", wr_req, 1'b0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_wdata_valid", wdata_valid, 1'b0);
    chk("rst_wdata_last", wdata_last, 1'b0);
    chk("rst_level", 64'(word_level), 64'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);

    // First word packing order
    for (int i = 1; i <= 4; i++) send_pix(16'(i));
    idle(2);
    chk("pack_level", 64'(word_level), 64'd1);
    chk("pack_head", wdata, 64'h0004_0003_0002_0001);
    chk("model_head", exp_q[0], 64'h0004_0003_0002_0001);

    // One burst, ack after 3 cycles, ready always high
    ack_mode = 1;
    ack_dly = 3;
    for (int i = 5; i <= 64; i++) send_pix(16'(i));
    wait_beats(16, 400, "burst1_beats");
    chk("burst1_addr", 64'(addr_log[0]), 64'd100);
    chk("burst1_count", 64'(addr_log.size()), 64'd1);
    chk("burst1_level", 64'(word_level), 64'd0);
    chk("burst1_req_low", wr_req, 1'b0);

    // Frame wrap with random ready and random pixel gaps
    reset_dut();
    ack_mode = 1;
    ack_dly = $urandom_range(0, 3);
    ready_rand = 1'b1;
    send_rand(320, 1'b1);
    wait_beats(80, 3000, "wrap_beats");
    chk("wrap_count", 64'(addr_log.size()), 64'd5);
    chk("wrap_addr3", 64'(addr_log[3]), 64'd148);
    chk("wrap_addr4", 64'(addr_log[4]), 64'd100);
    chk("wrap_level", 64'(word_level), 64'd0);

    // Overflow: nothing granted, push DEPTH+3 words
    reset_dut();
    send_rand((DEPTH + 3) * 4, 1'b0);
    idle(3);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_level", 64'(word_level), 64'(DEPTH));
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk("ovf_model_drop", 64'(m_drop), 64'd3);
    chk("ovf_req_waiting", wr_req, 1'b1);
    ack_mode = 1;
    ack_dly = 1;
    wait_beats(DEPTH, 3000, "ovf_drain_beats");
    chk("ovf_sticky", overflow, 1'b1);
    chk("ovf_drain_level", 64'(word_level), 64'd0);
    chk("ovf_drain_bursts", 64'(addr_log.size()), 64'(DEPTH / BL));

    // Restart from idle discards partial and buffered words, address returns to base
    reset_dut();
    ack_mode = 2;
    ready_rand = 1'b1;
    send_rand(64, 1'b1);
    wait_beats(16, 400, "rsta_first_beats");
    send_rand(6, 1'b0);
    idle(3);
    chk("rsta_level_pre", 64'(word_level), 64'd1);
    pulse_vs();
    idle(3);
    chk("rsta_level_post", 64'(word_level), 64'd0);
    send_rand(64, 1'b0);
    wait_beats(32, 400, "rsta_beats");
    chk("rsta_addr", 64'(addr_log[1]), 64'd100);

    // Restart during a burst: burst completes, remaining FIFO contents discarded
    reset_dut();
    send_rand(160, 1'b0);
    idle(3);
    chk("rstb_req_waiting", wr_req, 1'b1);
    ready_rand = 1'b1;
    ack_mode = 1;
    ack_dly = 2;
    begin
      int n = 0;
      while (beats_total < 2 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    @(posedge clk);
    #1;
    chk("rstb_in_burst", wdata_valid, 1'b1);
    pulse_vs();
    wait_beats(16, 400, "rstb_burst_done");
    idle(5);
    chk("rstb_level", 64'(word_level), 64'd0);
    chk("rstb_no_more_req", 64'(addr_log.size()), 64'd1);
    chk("rstb_req_low", wr_req, 1'b0);
    send_rand(64, 1'b1);
    wait_beats(32, 600, "rstb_beats");
    chk("rstb_addr", 64'(addr_log[1]), 64'd100);

    // Asynchronous reset in the middle of a burst
    send_rand(64, 1'b0);
    wait_valid(400);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_req", wr_req, 1'b0);
    chk("arst_valid", wdata_valid, 1'b0);
    chk("arst_last", wdata_last, 1'b0);
    chk("arst_wdata", wdata, 64'd0);
    chk("arst_wr_addr", 64'(wr_addr), 64'd0);
    chk("arst_level", 64'(word_level), 64'd0);
    chk("arst_overflow", overflow, 1'b0);
    chk("arst_drop_cnt", 64'(drop_cnt), 64'd0);
    reset_dut();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
